// File: rtl/ps2_key_controller.sv
// PS/2 set-2 scancode decoder for the game controls: tracks held keys,
// generates DAS/ARR auto-repeat and queues commands in a FWFT FIFO.
module ps2_key_controller #(
  parameter int unsigned DAS_CYCLES = 17000000,
  parameter int unsigned ARR_CYCLES = 5000000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [5:0] held,
  output logic       overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] DAS_LOAD = 32'(DAS_CYCLES - 1);
  localparam logic [31:0] ARR_LOAD = 32'(ARR_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} dec_state_e;

  dec_state_e  state_q, state_d;
  logic [5:0]  held_q;
  logic        ovf_q;
  logic        slot_v_q;
  logic [2:0]  slot_q;
  logic [31:0] rcnt_q;
  logic        pend_q, pend_d;
  logic [2:0]  pend_cmd_q, pend_cmd_d;
  logic [2:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] count_q;

  logic       make_ev, brk_ev;
  logic [2:0] ev_cmd;
  logic [3:0] std_m, ext_m;
  logic       make_new, repeatable, slot_brk, tick;
  logic       wr_en, rd_en, do_wr, full;
  logic [2:0] wr_cmd;

  // {hit, command} for a non-extended scancode
  function automatic logic [3:0] map_std(input logic [7:0] b);
    case (b)
      8'h1C:   return {1'b1, 3'd0};
      8'h23:   return {1'b1, 3'd1};
      8'h1D:   return {1'b1, 3'd2};
      8'h1B:   return {1'b1, 3'd3};
      8'h29:   return {1'b1, 3'd4};
      8'h4D:   return {1'b1, 3'd5};
      default: return '0;
    endcase
  endfunction

  // {hit, command} for an E0-prefixed scancode
  function automatic logic [3:0] map_ext(input logic [7:0] b);
    case (b)
      8'h6B:   return {1'b1, 3'd0};
      8'h74:   return {1'b1, 3'd1};
      8'h75:   return {1'b1, 3'd2};
      8'h72:   return {1'b1, 3'd3};
      default: return '0;
    endcase
  endfunction

  // Byte-stream decode: next prefix state and make/break event
  always_comb begin
    state_d = state_q;
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    ev_cmd  = '0;
    std_m   = map_std(data);
    ext_m   = map_ext(data);
    if (valid) begin
      case (state_q)
        S_IDLE: begin
          if (data == 8'hE0)      state_d = S_EXT;
          else if (data == 8'hF0) state_d = S_BRK;
          else if (std_m[3]) begin
            make_ev = 1'b1;
            ev_cmd  = std_m[2:0];
          end
        end
        S_EXT: begin
          state_d = S_IDLE;
          if (data == 8'hF0) state_d = S_EXT_BRK;
          else if (ext_m[3]) begin
            make_ev = 1'b1;
            ev_cmd  = ext_m[2:0];
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          if (std_m[3]) begin
            brk_ev = 1'b1;
            ev_cmd = std_m[2:0];
          end
        end
        default: begin
          state_d = S_IDLE;
          if (ext_m[3]) begin
            brk_ev = 1'b1;
            ev_cmd = ext_m[2:0];
          end
        end
      endcase
    end
  end

  assign make_new   = make_ev && !held_q[ev_cmd];
  assign repeatable = (ev_cmd == 3'd0) || (ev_cmd == 3'd1) || (ev_cmd == 3'd3);
  assign slot_brk   = brk_ev && slot_v_q && (slot_q == ev_cmd);
  // A tick in the same cycle as the slot key's release is discarded
  assign tick       = slot_v_q && (rcnt_q == '0) && !slot_brk;

  // Enqueue arbitration: make first, a colliding tick waits one cycle
  always_comb begin
    wr_en      = 1'b0;
    wr_cmd     = '0;
    pend_d     = pend_q;
    pend_cmd_d = pend_cmd_q;
    if (make_new) begin
      wr_en  = 1'b1;
      wr_cmd = ev_cmd;
      if (tick) begin
        pend_d     = 1'b1;
        pend_cmd_d = slot_q;
      end
    end else if (pend_q) begin
      wr_en      = 1'b1;
      wr_cmd     = pend_cmd_q;
      pend_d     = tick;
      if (tick) pend_cmd_d = slot_q;
    end else if (tick) begin
      wr_en  = 1'b1;
      wr_cmd = slot_q;
    end
  end

  assign cmd_valid = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign rd_en     = cmd_valid && cmd_ready;
  assign do_wr     = wr_en && (!full || rd_en);
  assign cmd       = cmd_valid ? mem_q[rptr_q] : '0;
  assign held      = held_q;
  assign overflow  = ovf_q;

  // Decoder prefix state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Held-key bits and the auto-repeat slot/counter
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q   <= '0;
      slot_v_q <= 1'b0;
      slot_q   <= '0;
      rcnt_q   <= '0;
    end else begin
      if (make_new) held_q[ev_cmd] <= 1'b1;
      if (brk_ev)   held_q[ev_cmd] <= 1'b0;
      if (make_new && repeatable) begin
        slot_v_q <= 1'b1;
        slot_q   <= ev_cmd;
        rcnt_q   <= DAS_LOAD;
      end else if (slot_brk) begin
        slot_v_q <= 1'b0;
        rcnt_q   <= '0;
      end else if (slot_v_q) begin
        rcnt_q <= (rcnt_q == '0) ? ARR_LOAD : rcnt_q - 32'd1;
      end
    end
  end

  // One-deep pending repeat
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= 1'b0;
      pend_cmd_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_cmd_q <= pend_cmd_d;
    end
  end

  // Command FIFO storage, pointers and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_wr) begin
        mem_q[wptr_q] <= wr_cmd;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (rd_en) rptr_q <= rptr_q + AW'(1);
      case ({do_wr, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (wr_en && full && !rd_en) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_controller.sv
// Scoreboard bench for ps2_key_controller with a keyboard-level reference model.
module tb_ps2_key_controller;
  localparam int DAS   = 20;
  localparam int ARR   = 5;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = '0;
  logic       valid = 1'b0;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [5:0] held;
  logic       overflow;

  ps2_key_controller #(.DAS_CYCLES(DAS), .ARR_CYCLES(ARR), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .cmd(cmd),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .held(held), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int c; int t; } exp_t;
  exp_t expq[$];
  exp_t mon_e;
  int checks = 0, passes = 0, cyc = 0, npop = 0;
  bit chk_time = 0;

  // reference model state: keyboard-level view
  bit m_ext, m_brk, m_ovf;
  bit m_held[6];
  int m_slot = -1;
  int m_next = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, want, cyc);
  endtask

  function automatic int lookup(input bit ext, input logic [7:0] b);
    if (ext) begin
      case (b)
        8'h6B: return 0; 8'h74: return 1; 8'h75: return 2; 8'h72: return 3;
        default: return -1;
      endcase
    end
    case (b)
      8'h1C: return 0; 8'h23: return 1; 8'h1D: return 2;
      8'h1B: return 3; 8'h29: return 4; 8'h4D: return 5;
      default: return -1;
    endcase
  endfunction

  task automatic push(input int c, input int t);
    exp_t e;
    if (!cmd_ready && expq.size() >= DEPTH) m_ovf = 1;
    else begin
      e.c = c; e.t = t;
      expq.push_back(e);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input logic [7:0] d);
    int mk, bk, k, old;
    bit rep, made;
    if (r) begin
      expq.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_slot = -1;
      foreach (m_held[i]) m_held[i] = 0;
      return;
    end
    mk = -1; bk = -1;
    if (v) begin
      if (!m_ext && !m_brk && d == 8'hE0) m_ext = 1;
      else if (!m_brk && d == 8'hF0) m_brk = 1;
      else begin
        k = lookup(m_ext, d);
        if (k >= 0) begin
          if (m_brk) bk = k; else mk = k;
        end
        m_ext = 0; m_brk = 0;
      end
    end
    old  = m_slot;
    rep  = (m_slot >= 0) && (cyc == m_next) && (bk != m_slot);
    made = 0;
    if (mk >= 0 && !m_held[mk]) begin
      m_held[mk] = 1;
      push(mk, cyc);
      made = 1;
      if (mk == 0 || mk == 1 || mk == 3) begin
        m_slot = mk;
        m_next = cyc + DAS;
      end
    end
    if (bk >= 0) begin
      m_held[bk] = 0;
      if (m_slot == bk) m_slot = -1;
    end
    if (rep) begin
      push(old, made ? cyc + 1 : cyc);
      if (m_slot == old) m_next = cyc + ARR;
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] d);
    logic [5:0] mh;
    @(negedge clk);
    rst = r; valid = v; data = d;
    @(posedge clk);
    cyc++;
    model_edge(r, v, d);
    #1;
    for (int i = 0; i < 6; i++) mh[i] = m_held[i];
    check("held", int'(held), int'(mh));
    check("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic send(input logic [7:0] b);
    step(0, 1, b);
    step(0, 0, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 8'h00);
  endtask

  // monitor: every accepted command is compared against the scoreboard
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      npop++;
      if (expq.size() == 0) check("unexpected_cmd", int'(cmd), -1);
      else begin
        mon_e = expq.pop_front();
        check("cmd", int'(cmd), mon_e.c);
        if (chk_time) check("cmd_time", cyc, mon_e.t);
      end
    end
  end

  logic [7:0] seq2 [7];
  logic [7:0] pool [15];
  int n0;

  initial begin
    seq2 = '{8'hE0, 8'h75, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    pool = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h29, 8'h4D, 8'h6B, 8'h74,
             8'h75, 8'h72, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hE1};

    step(1, 0, 8'h00);
    step(1, 0, 8'h00);
    check("rst_cmd_valid", int'(cmd_valid), 0);
    check("rst_cmd", int'(cmd), 0);

    // single LEFT make/break, not consumed yet
    step(0, 1, 8'h1C);
    check("t1_valid_next_cycle", int'(cmd_valid), 1);
    check("t1_cmd", int'(cmd), 0);
    step(0, 0, 8'h00);
    send(8'hF0); send(8'h1C);
    check("t1_held_released", int'(held[0]), 0);
    cmd_ready = 1'b1;
    idle(3);
    check("t1_drained", int'(cmd_valid), 0);

    // typematic suppression on extended ROTATE, then FSM back in idle
    chk_time = 1;
    foreach (seq2[i]) send(seq2[i]);
    send(8'h29); send(8'hF0); send(8'h29);
    idle(3);
    check("t2_drained", int'(cmd_valid), 0);

    // DAS/ARR timing on extended LEFT
    n0 = npop;
    step(0, 1, 8'hE0); step(0, 0, 8'h00);
    step(0, 1, 8'h6B);
    idle(59);
    step(0, 1, 8'hE0); step(0, 1, 8'hF0); step(0, 1, 8'h6B);
    check("t3_press_plus_repeats", npop - n0, 10);
    idle(20);
    check("t3_repeat_stopped", npop - n0, 10);

    // overflow with consumer stalled
    chk_time = 0;
    cmd_ready = 1'b0;
    send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'h23); send(8'hF0); send(8'h23);
    send(8'h1D); send(8'hF0); send(8'h1D);
    send(8'h1B); send(8'hF0); send(8'h1B);
    send(8'h29);
    check("t4_overflow_set", int'(overflow), 1);
    check("t4_head_is_left", int'(cmd), 0);
    send(8'hF0); send(8'h29);
    cmd_ready = 1'b1;
    idle(8);
    check("t4_drained", int'(cmd_valid), 0);
    check("t4_overflow_sticky", int'(overflow), 1);

    // repeat tick colliding with a HARD_DROP make
    chk_time = 1;
    step(0, 1, 8'h1C);
    idle(19);
    step(0, 1, 8'h29);
    idle(2);
    send(8'hF0); send(8'h29);
    send(8'hF0); send(8'h1C);
    idle(3);

    // reset mid-break with queued entries
    chk_time = 0;
    cmd_ready = 1'b0;
    send(8'h1C); send(8'h23);
    step(0, 1, 8'hE0); step(0, 1, 8'hF0);
    step(1, 0, 8'h00);
    check("t6_rst_empty", int'(cmd_valid), 0);
    check("t6_rst_cmd", int'(cmd), 0);
    step(0, 1, 8'h6B);
    idle(3);
    check("t6_plain_6b_unmapped", int'(cmd_valid), 0);

    // randomized byte stream
    cmd_ready = 1'b1;
    chk_time = 1;
    repeat (250) begin
      step(0, 1, pool[$urandom_range(0, 14)]);
      if ($urandom_range(0, 9) == 0) idle(30);
      else idle(int'($urandom_range(1, 6)));
    end
    idle(2);
    check("end_scoreboard_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
